mant_div_seq: RTL and testbench

Sequential restoring-division controller for the FP divide path. Accepts two normalized mantissas and produces their quotient plus a sticky bit, one quotient bit per cycle, by time-sharing a single WIDTH+1-bit ripple subtractor built from the existing full-adder cells. Sits between exponent/sign handling and the rounding/normalization stage of the divider.

---
 rtl/mant_div_seq.sv | 107 ++++++++++
 tb/tb_mant_div_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mant_div_seq.sv
// mant_div_seq: restoring mantissa divider, one quotient bit per cycle over a shared ripple subtractor.
// Define DIV_EARLY_TERM_EN to finish as soon as the partial remainder reaches zero.
module mant_div_seq #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   quotient,
    output logic             sticky,
    output logic             div_by_zero
);
    localparam int IW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t         state_q, state_d;
    logic [WIDTH:0] rem_q, rem_d, quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           sticky_q, sticky_d, dbz_q, dbz_d;
    logic [WIDTH:0] sub_b, diff, rem_nxt;
    logic [WIDTH+1:0] c;
    logic           no_borrow, last;
    // R - B as R + ~B + 1 through a chain of full-adder cells; carry out high means no borrow
    assign sub_b = ~{1'b0, dvs_q};
    assign c[0]  = 1'b1;
    for (genvar g = 0; g <= WIDTH; g++) begin : g_fa
        assign diff[g]  = rem_q[g] ^ sub_b[g] ^ c[g];
        assign c[g + 1] = (rem_q[g] & sub_b[g]) | (c[g] & (rem_q[g] ^ sub_b[g]));
    end
    assign no_borrow = c[WIDTH + 1];
    assign rem_nxt   = (no_borrow ? diff : rem_q) << 1;
`ifdef DIV_EARLY_TERM_EN
    assign last = (idx_q == '0) || (rem_nxt == '0);
`else
    assign last = (idx_q == '0);
`endif
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        idx_d    = idx_q;
        sticky_d = sticky_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sticky_d = 1'b0;
                    if (divisor == '0) begin
                        quo_d   = '1;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = {1'b0, dividend};
                        dvs_d   = divisor;
                        quo_d   = '0;
                        dbz_d   = 1'b0;
                        idx_d   = IW'(WIDTH);
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                quo_d = quo_q | ({{WIDTH{1'b0}}, no_borrow} << idx_q);
                rem_d = rem_nxt;
                idx_d = idx_q - IW'(1);
                if (last) begin
                    sticky_d = |rem_nxt;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            idx_q    <= '0;
            sticky_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            idx_q    <= idx_d;
            sticky_q <= sticky_d;
            dbz_q    <= dbz_d;
        end
    end
    assign ready       = (state_q == IDLE) || (state_q == DONE);
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign sticky      = sticky_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_mant_div_seq.sv
// tb_mant_div_seq: directed self-checking bench for mant_div_seq at WIDTH = 24.
module tb_mant_div_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] dividend = '0;
    logic [23:0] divisor = '0;
    logic        ready, busy, done, sticky, div_by_zero;
    logic [24:0] quotient;
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          lat_eq, lat_c8;

    mant_div_seq #(.WIDTH(24)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .ready(ready), .busy(busy), .done(done), .quotient(quotient),
        .sticky(sticky), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [23:0] a, input logic [23:0] b);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1 start = 1'b0;
        dividend = '0;
        divisor = '0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
`ifdef DIV_EARLY_TERM_EN
        lat_eq = 2;
        lat_c8 = 3;
`else
        lat_eq = 26;
        lat_c8 = 26;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_outs", {4'd0, quotient, sticky, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        launch(24'h800000, 24'h800000);
        @(negedge clk);
        chk("eq_busy", {30'd0, busy, ready}, 32'd2);
        wait_done(cyc);
        chk("eq_lat", cyc + 1, lat_eq);
        chk("eq_quo", {7'd0, quotient}, 32'h1000000);
        chk("eq_flags", {30'd0, sticky, div_by_zero}, 32'd0);
        chk("eq_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        chk("eq_pulse", {31'd0, done}, 32'd0);
        chk("eq_hold", {7'd0, quotient}, 32'h1000000);

        launch(24'hC00000, 24'h800000);
        wait_done(cyc);
        chk("c8_lat", cyc, lat_c8);
        chk("c8_quo", {7'd0, quotient}, 32'h1800000);
        chk("c8_sticky", {31'd0, sticky}, 32'd0);
        @(negedge clk);

        launch(24'h800000, 24'hC00000);
        wait_done(cyc);
        chk("8c_lat", cyc, 26);
        chk("8c_quo", {7'd0, quotient}, 32'h0AAAAAA);
        chk("8c_sticky", {30'd0, sticky, div_by_zero}, 32'd2);
        @(negedge clk);

        launch(24'hABCDEF, 24'h000000);
        wait_done(cyc);
        chk("dz_lat", cyc, 1);
        chk("dz_quo", {7'd0, quotient}, 32'h1FFFFFF);
        chk("dz_flags", {30'd0, sticky, div_by_zero}, 32'd1);
        @(negedge clk);
        chk("dz_idle", {30'd0, done, ready}, 32'd1);

        launch(24'h800000, 24'hC00000);
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                cyc = k;
                break;
            end
            start = (k == 5 || k == 10);
            dividend = 24'hC00000;
            divisor = 24'h800000;
        end
        start = 1'b0;
        chk("ign_lat", cyc, 26);
        chk("ign_quo", {7'd0, quotient}, 32'h0AAAAAA);
        chk("ign_sticky", {31'd0, sticky}, 32'd1);
        launch(24'hC00000, 24'h800000);
        wait_done(cyc);
        chk("b2b_lat", cyc + 1, lat_c8 + 1);
        chk("b2b_quo", {7'd0, quotient}, 32'h1800000);
        @(negedge clk);

        launch(24'h800000, 24'hC00000);
        repeat (11) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_ready", {30'd0, ready, busy}, 32'd2);
        chk("ar_outs", {3'd0, done, quotient, sticky, div_by_zero}, 32'd0);
        @(negedge clk);
        chk("ar_nodone", {31'd0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_idle", {30'd0, done, ready}, 32'd1);
        launch(24'h800000, 24'hC00000);
        wait_done(cyc);
        chk("post_lat", cyc, 26);
        chk("post_quo", {7'd0, quotient}, 32'h0AAAAAA);
        chk("post_sticky", {30'd0, sticky, div_by_zero}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
